// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: clears x1..x31 after reset, then passes pipeline traffic to the register file
// and grants paused-CPU debug reads/writes through write port and read port 2.
module regfile_port_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_run,
   input  logic [4:0]       cpu_ra1,
   input  logic [4:0]       cpu_ra2,
   input  logic [4:0]       cpu_wa,
   input  logic             cpu_we,
   input  logic [WIDTH-1:0] cpu_wd,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [4:0]       dbg_addr,
   input  logic [WIDTH-1:0] dbg_wdata,
   output logic             dbg_ack,
   output logic [WIDTH-1:0] dbg_rdata,
   output logic [4:0]       rf_ra1,
   output logic [4:0]       rf_ra2,
   output logic [4:0]       rf_wa,
   output logic             rf_we,
   output logic [WIDTH-1:0] rf_wd,
   input  logic [WIDTH-1:0] rf_rd2,
   output logic             cpu_stall,
   output logic             clear_done
);
   typedef enum logic [1:0] {CLEAR, RUN, DBG, ACK} state_e;
   state_e           state_q, state_d;
   logic [4:0]       clr_cnt_q, clr_cnt_d;
   logic             dbg_ack_q, dbg_ack_d;
   logic             clear_done_q, clear_done_d;
   logic [WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
   logic             grant;
   assign grant      = state_q == RUN && dbg_req && !cpu_run;
   assign rf_ra1     = cpu_ra1;
   assign dbg_ack    = dbg_ack_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign clear_done = clear_done_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CLEAR;
         clr_cnt_q    <= 5'd1;
         dbg_ack_q    <= 1'b0;
         dbg_rdata_q  <= '0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         dbg_ack_q    <= dbg_ack_d;
         dbg_rdata_q  <= dbg_rdata_d;
         clear_done_q <= clear_done_d;
      end
   end
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      dbg_ack_d    = 1'b0;
      dbg_rdata_d  = dbg_rdata_q;
      clear_done_d = clear_done_q;
      rf_ra2       = cpu_ra2;
      rf_wa        = cpu_wa;
      rf_wd        = cpu_wd;
      rf_we        = 1'b0;
      cpu_stall    = 1'b1;
      case (state_q)
         CLEAR: begin
            rf_we = 1'b1;
            rf_wa = clr_cnt_q;
            rf_wd = '0;
            clr_cnt_d = clr_cnt_q == 5'd31 ? clr_cnt_q : clr_cnt_q + 5'd1;
            state_d = clr_cnt_q == 5'd31 ? RUN : CLEAR;
            clear_done_d = clr_cnt_q == 5'd31;
         end
         RUN: begin
            rf_we = cpu_we && cpu_wa != 5'd0;
            cpu_stall = grant;
            state_d = grant ? DBG : RUN;
         end
         DBG: begin
            rf_ra2 = dbg_addr;
            rf_wa = dbg_addr;
            rf_wd = dbg_wdata;
            rf_we = dbg_we && dbg_addr != 5'd0;
            // writes return the value just stored, matching the file's write-first bypass
            dbg_rdata_d = dbg_we ? dbg_wdata : (dbg_addr == 5'd0 ? '0 : rf_rd2);
            dbg_ack_d = 1'b1;
            state_d = ACK;
         end
         ACK: state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl: directed table plus randomized traffic checked against a
// transaction-level model of the port controller and an attached register file model.
module tb_regfile_port_ctrl;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst, cpu_run, cpu_we, dbg_req, dbg_we, dbg_ack, rf_we, cpu_stall, clear_done, preload;
   logic [4:0] cpu_ra1, cpu_ra2, cpu_wa, dbg_addr, rf_ra1, rf_ra2, rf_wa;
   logic [W-1:0] cpu_wd, dbg_wdata, dbg_rdata, rf_wd, rf_rd2;
   logic [W-1:0] rf [32];
   int n_vec = 0, n_err = 0;
   bit m_clear, m_done;
   int m_idx, m_phase;
   logic [W-1:0] m_rdata;
   logic [W-1:0] m_mem [32];
   typedef struct {
      bit run, req, dwe;
      logic [4:0] da;
      logic [W-1:0] dwd;
      bit cwe;
      logic [4:0] cwa;
      logic [W-1:0] cwd;
      bit e_we, e_stall, e_ack, crd;
      logic [W-1:0] e_rd;
   } vec_t;
   vec_t tbl [30];
   regfile_port_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .cpu_run(cpu_run), .cpu_ra1(cpu_ra1), .cpu_ra2(cpu_ra2),
      .cpu_wa(cpu_wa), .cpu_we(cpu_we), .cpu_wd(cpu_wd), .dbg_req(dbg_req), .dbg_we(dbg_we),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
      .rf_rd2(rf_rd2), .cpu_stall(cpu_stall), .clear_done(clear_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (preload) for (int i = 0; i < 32; i++) rf[i] <= '1;
      else if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
   assign rf_rd2 = rf_ra2 == 5'd0 ? '0 : (rf_we && rf_wa == rf_ra2) ? rf_wd : rf[rf_ra2];
   task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chkb(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_chk();
      logic e_we;
      logic [4:0] e_wa;
      logic [W-1:0] e_wd;
      e_wa = cpu_wa;
      e_wd = cpu_wd;
      if (m_clear) begin
         e_we = 1'b1;
         e_wa = m_idx[4:0];
         e_wd = '0;
      end else if (m_phase == 1) begin
         e_we = dbg_we && dbg_addr != 5'd0;
         e_wa = dbg_addr;
         e_wd = dbg_wdata;
         chkw("m_ra2", {27'd0, rf_ra2}, {27'd0, dbg_addr});
      end else if (m_phase == 2) e_we = 1'b0;
      else begin
         e_we = cpu_we && cpu_wa != 5'd0;
         chkw("m_ra2", {27'd0, rf_ra2}, {27'd0, cpu_ra2});
      end
      chkb("m_we", rf_we, e_we);
      if (e_we) begin
         chkw("m_wa", {27'd0, rf_wa}, {27'd0, e_wa});
         chkw("m_wd", rf_wd, e_wd);
      end
      chkb("m_stall", cpu_stall, m_clear || m_phase != 0 || (dbg_req && !cpu_run));
      chkb("m_ack", dbg_ack, m_phase == 2);
      chkw("m_rdata", dbg_rdata, m_rdata);
      chkb("m_done", clear_done, m_done);
      chkw("m_ra1", {27'd0, rf_ra1}, {27'd0, cpu_ra1});
   endtask
   task automatic model_upd();
      if (rst) begin
         m_clear = 1; m_idx = 1; m_phase = 0; m_rdata = '0; m_done = 0;
      end else if (m_clear) begin
         m_mem[m_idx] = '0;
         if (m_idx == 31) begin m_clear = 0; m_done = 1; end
         else m_idx++;
      end else if (m_phase == 1) begin
         m_rdata = dbg_we ? dbg_wdata : (dbg_addr == 5'd0 ? '0 : m_mem[dbg_addr]);
         if (dbg_we && dbg_addr != 5'd0) m_mem[dbg_addr] = dbg_wdata;
         m_phase = 2;
      end else if (m_phase == 2) m_phase = 0;
      else begin
         if (cpu_we && cpu_wa != 5'd0) m_mem[cpu_wa] = cpu_wd;
         if (dbg_req && !cpu_run) m_phase = 1;
      end
   endtask
   task automatic tick();
      #1 model_chk();
      @(posedge clk);
      model_upd();
      #1;
   endtask
   task automatic clear_seq();
      for (int i = 1; i <= 31; i++) begin
         #1;
         chkb("clr_we", rf_we, 1'b1);
         chkw("clr_wa", {27'd0, rf_wa}, i);
         chkw("clr_wd", rf_wd, '0);
         chkb("clr_stall", cpu_stall, 1'b1);
         chkb("clr_done", clear_done, 1'b0);
         tick();
      end
      #1;
      chkb("clr_done_end", clear_done, 1'b1);
      chkb("clr_stall_end", cpu_stall, 1'b0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
      $fatal(1, "watchdog");
   end
   initial begin
      bit act;
      // run, req, dwe, da, dwd, cwe, cwa, cwd, e_we, e_stall, e_ack, crd, e_rd
      tbl[0]  = '{1, 0, 0, 0, 0, 1, 5, 'h1234, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 1, 0, 'h1234, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 1, 7, 'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[3]  = '{0, 1, 1, 7, 'hDEADBEEF, 0, 0, 0, 1, 1, 0, 0, 0};
      tbl[4]  = '{0, 0, 1, 7, 'hDEADBEEF, 0, 0, 0, 0, 1, 1, 1, 'hDEADBEEF};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF};
      tbl[6]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[7]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 1, 1, 'h1234};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1234};
      tbl[10] = '{0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[11] = '{0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[12] = '{0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 1, 1, 'hDEADBEEF};
      tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[15] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[18] = '{0, 1, 1, 9, 'h55AA, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[19] = '{0, 1, 1, 9, 'h55AA, 1, 3, 'hFFFF, 1, 1, 0, 0, 0};
      tbl[20] = '{0, 0, 1, 9, 'h55AA, 1, 3, 'hFFFF, 0, 1, 1, 1, 'h55AA};
      tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[22] = '{0, 1, 1, 0, 'h1111, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[23] = '{0, 1, 1, 0, 'h1111, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[24] = '{0, 0, 1, 0, 'h1111, 0, 0, 0, 0, 1, 1, 1, 'h1111};
      tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[26] = '{0, 1, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[27] = '{1, 1, 0, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tbl[28] = '{1, 0, 0, 9, 0, 0, 0, 0, 0, 1, 1, 1, 'h55AA};
      tbl[29] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h55AA};
      for (int i = 0; i < 32; i++) m_mem[i] = '1;
      rst = 1; preload = 1; cpu_run = 0; cpu_we = 0; cpu_wa = 0; cpu_wd = 0;
      cpu_ra1 = 0; cpu_ra2 = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      @(posedge clk);
      model_upd();
      #1 preload = 0;
      #1;
      chkb("rst_ack", dbg_ack, 1'b0);
      chkw("rst_rdata", dbg_rdata, '0);
      chkb("rst_done", clear_done, 1'b0);
      tick();
      rst = 0;
      clear_seq();
      for (int i = 1; i < 32; i++) chkw("clr_mem", rf[i], '0);
      foreach (tbl[k]) begin
         cpu_run = tbl[k].run; dbg_req = tbl[k].req; dbg_we = tbl[k].dwe;
         dbg_addr = tbl[k].da; dbg_wdata = tbl[k].dwd; cpu_we = tbl[k].cwe;
         cpu_wa = tbl[k].cwa; cpu_wd = tbl[k].cwd; cpu_ra1 = 5'(k); cpu_ra2 = 5'(k + 1);
         #1;
         chkb("tbl_we", rf_we, tbl[k].e_we);
         chkb("tbl_stall", cpu_stall, tbl[k].e_stall);
         chkb("tbl_ack", dbg_ack, tbl[k].e_ack);
         if (tbl[k].crd) chkw("tbl_rdata", dbg_rdata, tbl[k].e_rd);
         tick();
      end
      chkw("mask_x3", rf[3], '0);
      chkw("dbg_x9", rf[9], 'h55AA);
      // a request blocked by a running CPU waits, then completes once the CPU pauses
      cpu_run = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 5; cpu_we = 0;
      repeat (10) begin
         #1;
         chkb("gate_ack", dbg_ack, 1'b0);
         chkb("gate_stall", cpu_stall, 1'b0);
         tick();
      end
      cpu_run = 0;
      tick();
      #1 chkb("gate_ack_early", dbg_ack, 1'b0);
      tick();
      dbg_req = 0;
      #1;
      chkb("gate_ack_late", dbg_ack, 1'b1);
      chkw("gate_rdata", dbg_rdata, 'h1234);
      tick();
      // reset during the access cycle aborts the transaction and restarts the clear
      dbg_req = 1; dbg_we = 1; dbg_addr = 12; dbg_wdata = 'hA5A5;
      tick();
      rst = 1;
      tick();
      rst = 0; dbg_req = 0;
      #1;
      chkb("abort_ack", dbg_ack, 1'b0);
      chkb("abort_done", clear_done, 1'b0);
      clear_seq();
      act = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = $urandom_range(0, 499) == 0;
         cpu_run = $urandom_range(0, 3) == 0;
         cpu_we = 1'($urandom); cpu_wa = 5'($urandom); cpu_wd = $urandom;
         cpu_ra1 = 5'($urandom); cpu_ra2 = 5'($urandom);
         if (dbg_ack) act = 0;
         else if (!act && $urandom_range(0, 2) == 0) begin
            act = 1; dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
         end
         dbg_req = act;
         tick();
      end
      rst = 0; dbg_req = 0; cpu_we = 0;
      repeat (40) tick();
      for (int i = 1; i < 32; i++) chkw("final_mem", rf[i], m_mem[i]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
